pipeline_control_ldst_responder: RTL and testbench
==================================================

// Module: pipeline_control_ldst_responder
// PURPOSE
//  Memory-side responder for the pipeline-control load/store port (USE/REQ/BUSY/ORDER/RW/ADDR/DATA, REQ+DATA reply).
//  Serves one client request at a time: latches it, issues it as a word-aligned access with byte mask on the data-memory port,
//  lane-aligns read data, and returns a single-cycle completion to the client. Sits between pipeline-control clients
//  (e.g. interrupt-handler IDT fetch) and the core data-memory arbiter.
// PARAMETERS
//  P_BIG_ENDIAN  1  1: addr[1:0]=0 selects bits[31:24]; 0: addr[1:0]=0 selects bits[7:0]
//  P_TIMEOUT     0  cycles allowed in WAIT before abort with fault; 0 disables the timeout (counter width 16)
// PORTS
//  iCLOCK        in   1   clock, all state on rising edge
//  inRESET       in   1   asynchronous reset, active-low
//  iRESET_SYNC   in   1   synchronous reset, same effect as inRESET
//  iLDST_USE     in   1   client owns the port
//  iLDST_REQ     in   1   client request strobe
//  oLDST_BUSY    out  1   responder not accepting (state != IDLE)
//  iLDST_ORDER   in   2   00 byte, 01 half, 10 word, 11 none
//  iLDST_RW      in   1   0 read, 1 write
//  iLDST_ADDR    in   32  byte address
//  iLDST_DATA    in   32  write data, right-justified
//  oLDST_REQ     out  1   completion pulse, 1 cycle
//  oLDST_DATA    out  32  read data, zero-extended, right-justified; valid with oLDST_REQ
//  oLDST_FAULT   out  1   with oLDST_REQ: misaligned or timed out
//  oMEM_REQ      out  1   memory request, held until accepted
//  iMEM_LOCK     in   1   memory busy; request accepted when oMEM_REQ && !iMEM_LOCK
//  oMEM_RW       out  1   0 read, 1 write
//  oMEM_MASK     out  4   byte enables, bit3 = bits[31:24]
//  oMEM_ADDR     out  32  {addr[31:2],2'b00}
//  oMEM_DATA     out  32  write data replicated into the selected lanes
//  iMEM_VALID    in   1   read data / write ack, 1 cycle
//  iMEM_DATA     in   32  read word
// BEHAVIOUR
//  Reset (async or sync): state IDLE, all outputs 0, timeout counter 0, latched request 0.
//  States:
//   IDLE   - accept on iLDST_USE && iLDST_REQ: latch ORDER, RW, ADDR, DATA.
//            ORDER=11 -> RESP, data 0, no fault.
//            Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with fault.
//            Otherwise -> ISSUE.
//   ISSUE  - oMEM_REQ=1 with stable RW/MASK/ADDR/DATA. On !iMEM_LOCK -> WAIT and drop oMEM_REQ next cycle.
//   WAIT   - On iMEM_VALID: latch lane-extracted data (reads; writes latch 0) -> RESP.
//            If P_TIMEOUT!=0 and the counter reaches P_TIMEOUT-1 without iMEM_VALID -> RESP with fault, data 0.
//   RESP   - oLDST_REQ=1 for exactly one cycle, oLDST_DATA/oLDST_FAULT valid -> IDLE.
//  Masks (big endian): byte = 4'b1000>>addr[1:0]; half = addr[1] ? 0011 : 1100; word = 1111.
//  P_BIG_ENDIAN=0 mirrors the lane selection.
//  Write data: byte replicated x4, half replicated x2, word as-is.
//  Latency, accepted at cycle 0 with memory unlocked: ISSUE c1; WAIT c2; iMEM_VALID at cN gives oLDST_REQ at cN+1.
//  Best case is oLDST_REQ at c3 (VALID in c2). Fault / none-order completes in 1 cycle (oLDST_REQ at c1).
//  oLDST_BUSY=1 in every non-IDLE state, including RESP, so back-to-back requests are accepted no sooner than the cycle after RESP.
//  iLDST_REQ outside IDLE: ignored, not queued. Changes to client inputs after acceptance have no effect.
//  iMEM_VALID outside WAIT: ignored. Timeout counter clears on entry to WAIT.
//  Reset mid-operation: immediate return to IDLE, oMEM_REQ drops, no completion is issued.
// TESTING
//  Word read @0x100, LOCK=0, VALID+0xDEADBEEF 2 cycles after REQ -> MEM_ADDR 0x100, MASK 1111, oLDST_REQ 1 cyc, DATA 0xDEADBEEF.
//  Byte read @0x103, mem 0x11223344 -> MASK 0001, oLDST_DATA 0x00000044.
//  Half read @0x102 -> oLDST_DATA 0x00003344.
//  Half write 0xABCD @0x102 -> oMEM_DATA 0xABCDABCD, MASK 0011, RW=1; VALID ack -> oLDST_REQ, DATA 0.
//  Word read @0x101 -> no oMEM_REQ, oLDST_REQ and oLDST_FAULT both 1 the next cycle.
//  ORDER=11 -> no oMEM_REQ, oLDST_REQ with DATA 0, FAULT 0.
//  iMEM_LOCK held 5 cycles -> oMEM_REQ held stable for 6 cycles, BUSY=1 throughout.
//  P_TIMEOUT=8 with no VALID -> FAULT pulse after 8 WAIT cycles.
//  inRESET asserted in WAIT -> all outputs 0, a late VALID is ignored, and the next request is served normally.

Source files
------------

// File: rtl/pipeline_control_ldst_responder.sv
// Load/store responder for pipeline-control clients: one request at a time,
// issued as an aligned, byte-masked word access; read data returned lane-aligned.
module pipeline_control_ldst_responder #(
  parameter bit P_BIG_ENDIAN = 1'b1,
  parameter int P_TIMEOUT    = 0
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iLDST_USE,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic [1:0]  iLDST_ORDER,
  input  logic        iLDST_RW,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_REQ,
  output logic [31:0] oLDST_DATA,
  output logic        oLDST_FAULT,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam bit          TMO_EN   = (P_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  order_q;
  logic        rw_q;
  logic [1:0]  lane_q;
  logic [15:0] tmo_cnt;

  logic [1:0]  a_bsel;
  logic        a_hsel;
  logic [3:0]  a_mask;
  logic [31:0] a_wdata;
  logic        a_misal;
  logic [1:0]  r_bsel;
  logic        r_hsel;
  logic [31:0] r_shift;
  logic [31:0] r_data;

  // Lane index counts from bit 0; big endian flips the address lane.
  always_comb begin
    a_bsel  = P_BIG_ENDIAN ? ~iLDST_ADDR[1:0] : iLDST_ADDR[1:0];
    a_hsel  = a_bsel[1];
    a_mask  = 4'b0000;
    a_wdata = 32'd0;
    a_misal = 1'b0;
    unique case (iLDST_ORDER)
      2'b00: begin
        a_mask  = 4'b0001 << a_bsel;
        a_wdata = {4{iLDST_DATA[7:0]}};
      end
      2'b01: begin
        a_mask  = a_hsel ? 4'b1100 : 4'b0011;
        a_wdata = {2{iLDST_DATA[15:0]}};
        a_misal = iLDST_ADDR[0];
      end
      2'b10: begin
        a_mask  = 4'b1111;
        a_wdata = iLDST_DATA;
        a_misal = |iLDST_ADDR[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    r_bsel  = P_BIG_ENDIAN ? ~lane_q : lane_q;
    r_hsel  = r_bsel[1];
    r_shift = iMEM_DATA >> {r_bsel, 3'b000};
    r_data  = 32'd0;
    unique case (order_q)
      2'b00:   r_data = {24'd0, r_shift[7:0]};
      2'b01:   r_data = r_hsel ? {16'd0, iMEM_DATA[31:16]}
                               : {16'd0, iMEM_DATA[15:0]};
      2'b10:   r_data = iMEM_DATA;
      default: r_data = 32'd0;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= S_IDLE;
      order_q     <= 2'd0;
      rw_q        <= 1'b0;
      lane_q      <= 2'd0;
      tmo_cnt     <= 16'd0;
      oLDST_BUSY  <= 1'b0;
      oLDST_REQ   <= 1'b0;
      oLDST_DATA  <= 32'd0;
      oLDST_FAULT <= 1'b0;
      oMEM_REQ    <= 1'b0;
      oMEM_RW     <= 1'b0;
      oMEM_MASK   <= 4'd0;
      oMEM_ADDR   <= 32'd0;
      oMEM_DATA   <= 32'd0;
    end else if (iRESET_SYNC) begin
      state       <= S_IDLE;
      order_q     <= 2'd0;
      rw_q        <= 1'b0;
      lane_q      <= 2'd0;
      tmo_cnt     <= 16'd0;
      oLDST_BUSY  <= 1'b0;
      oLDST_REQ   <= 1'b0;
      oLDST_DATA  <= 32'd0;
      oLDST_FAULT <= 1'b0;
      oMEM_REQ    <= 1'b0;
      oMEM_RW     <= 1'b0;
      oMEM_MASK   <= 4'd0;
      oMEM_ADDR   <= 32'd0;
      oMEM_DATA   <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (iLDST_USE && iLDST_REQ) begin
            order_q    <= iLDST_ORDER;
            rw_q       <= iLDST_RW;
            lane_q     <= iLDST_ADDR[1:0];
            oMEM_RW    <= iLDST_RW;
            oMEM_MASK  <= a_mask;
            oMEM_ADDR  <= {iLDST_ADDR[31:2], 2'b00};
            oMEM_DATA  <= a_wdata;
            oLDST_BUSY <= 1'b1;
            if (iLDST_ORDER == 2'b11 || a_misal) begin
              state       <= S_RESP;
              oLDST_REQ   <= 1'b1;
              oLDST_DATA  <= 32'd0;
              oLDST_FAULT <= a_misal;
            end else begin
              state    <= S_ISSUE;
              oMEM_REQ <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!iMEM_LOCK) begin
            state    <= S_WAIT;
            oMEM_REQ <= 1'b0;
            tmo_cnt  <= 16'd0;
          end
        end
        S_WAIT: begin
          if (iMEM_VALID) begin
            state       <= S_RESP;
            oLDST_REQ   <= 1'b1;
            oLDST_DATA  <= rw_q ? 32'd0 : r_data;
            oLDST_FAULT <= 1'b0;
          end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
            state       <= S_RESP;
            oLDST_REQ   <= 1'b1;
            oLDST_DATA  <= 32'd0;
            oLDST_FAULT <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          oLDST_BUSY  <= 1'b0;
          oLDST_REQ   <= 1'b0;
          oLDST_FAULT <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_control_ldst_responder.sv
// Directed and randomized bench for pipeline_control_ldst_responder
// (big endian, timeout of 8 cycles) against a byte-level reference model.
module tb_pipeline_control_ldst_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_sync;
  logic        use_i, req_i, rw_i;
  logic [1:0]  order_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy, ldst_req, fault;
  logic [31:0] ldst_data;
  logic        mem_req, mem_lock, mem_rw, mem_valid;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipeline_control_ldst_responder #(
    .P_BIG_ENDIAN(1'b1),
    .P_TIMEOUT(8)
  ) dut (
    .iCLOCK(clk),
    .inRESET(rst_n),
    .iRESET_SYNC(rst_sync),
    .iLDST_USE(use_i),
    .iLDST_REQ(req_i),
    .oLDST_BUSY(busy),
    .iLDST_ORDER(order_i),
    .iLDST_RW(rw_i),
    .iLDST_ADDR(addr_i),
    .iLDST_DATA(wdata_i),
    .oLDST_REQ(ldst_req),
    .oLDST_DATA(ldst_data),
    .oLDST_FAULT(fault),
    .oMEM_REQ(mem_req),
    .iMEM_LOCK(mem_lock),
    .oMEM_RW(mem_rw),
    .oMEM_MASK(mem_mask),
    .oMEM_ADDR(mem_addr),
    .oMEM_DATA(mem_wdata),
    .iMEM_VALID(mem_valid),
    .iMEM_DATA(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mreq"}, 32'(mem_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_lreq"}, 32'(ldst_req), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_mask"}, 32'(mem_mask), 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdat"}, mem_wdata, 0);
    chk({tag, "_rdat"}, ldst_data, 0);
    chk({tag, "_rw"}, 32'(mem_rw), 0);
  endtask

  // Starts a request at a negedge; returns after the accepting edge + #1.
  task automatic start_req(input logic [1:0] order, input logic rw,
                           input logic [31:0] addr, input logic [31:0] wd);
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("idle_before_req", 32'(busy), 0);
    use_i = 1'b1; req_i = 1'b1;
    order_i = order; rw_i = rw; addr_i = addr; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0; use_i = 1'($urandom);
    order_i = 2'($urandom); rw_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
  endtask

  task automatic txn(input logic [1:0] order, input logic rw,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] mword, input int lock_n,
                     input int vdly);
    int n, off, b;
    logic [3:0] emask;
    logic [31:0] ewd, erd;
    bit direct, efault, tmo;
    n = (order == 0) ? 1 : (order == 1) ? 2 : 4;
    off = int'(addr & 32'h3);
    direct = (order == 3) || (off % n != 0);
    efault = (order != 3) && direct;
    tmo = (vdly >= 8);
    emask = 4'd0;
    erd = 32'd0;
    if (!direct) begin
      for (int i = 0; i < n; i++) begin
        b = off + i;
        emask = emask | 4'(1 << (3 - b));
        erd = (erd << 8) | ((mword >> (8 * (3 - b))) & 32'hff);
      end
    end
    if (order == 0) ewd = 32'(wd[7:0]) * 32'h01010101;
    else if (order == 1) ewd = 32'(wd[15:0]) * 32'h00010001;
    else ewd = wd;
    if (rw || tmo) erd = 32'd0;

    start_req(order, rw, addr, wd);
    if (direct) begin
      @(negedge clk);
      chk("direct_lreq", 32'(ldst_req), 1);
      chk("direct_fault", 32'(fault), 32'(efault));
      chk("direct_data", ldst_data, 0);
      chk("direct_mreq", 32'(mem_req), 0);
    end else begin
      for (int c = 0; c <= lock_n; c++) begin
        mem_lock = (c < lock_n);
        mem_valid = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        chk("issue_mreq", 32'(mem_req), 1);
        chk("issue_busy", 32'(busy), 1);
        chk("issue_mask", 32'(mem_mask), 32'(emask));
        chk("issue_addr", mem_addr, addr & 32'hffff_fffc);
        chk("issue_rw", 32'(mem_rw), 32'(rw));
        chk("issue_wdat", mem_wdata, ewd);
        @(posedge clk); #1;
      end
      mem_lock = 1'b0;
      for (int k = 0; k < 64; k++) begin
        mem_valid = (k == vdly);
        mem_rdata = (k == vdly) ? mword : $urandom;
        @(negedge clk);
        chk("wait_mreq", 32'(mem_req), 0);
        chk("wait_lreq", 32'(ldst_req), 0);
        @(posedge clk); #1;
        if (k == vdly || k == 7) break;
      end
      mem_valid = 1'b0;
      @(negedge clk);
      chk("resp_lreq", 32'(ldst_req), 1);
      chk("resp_data", ldst_data, erd);
      chk("resp_fault", 32'(fault), 32'(tmo));
      chk("resp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_lreq", 32'(ldst_req), 0);
    chk("after_busy", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; rst_sync = 1'b0;
    use_i = 1'b0; req_i = 1'b0; rw_i = 1'b0; order_i = 2'd0;
    addr_i = 32'd0; wdata_i = 32'd0;
    mem_lock = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
    #1;
    chk_quiet("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    txn(2'b00, 1'b0, 32'h103, 32'h0, 32'h11223344, 0, 0);
    txn(2'b01, 1'b0, 32'h102, 32'h0, 32'h11223344, 0, 1);
    txn(2'b01, 1'b1, 32'h102, 32'hABCD, 32'h55AA55AA, 0, 0);
    txn(2'b00, 1'b0, 32'h100, 32'h0, 32'h11223344, 1, 2);
    txn(2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0);
    txn(2'b01, 1'b1, 32'h203, 32'h1234, 32'h0, 0, 0);
    txn(2'b11, 1'b0, 32'h104, 32'h0, 32'h0, 0, 0);
    txn(2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 5, 2);
    txn(2'b10, 1'b0, 32'h44, 32'h0, 32'h12345678, 0, 20);
    txn(2'b10, 1'b0, 32'h48, 32'h0, 32'h87654321, 0, 7);

    // Async reset while waiting for memory: no completion afterwards.
    start_req(2'b10, 1'b0, 32'h200, 32'h0);
    mem_lock = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    chk("late_valid_lreq", 32'(ldst_req), 0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_lreq2", 32'(ldst_req), 0);
    chk("late_valid_busy", 32'(busy), 0);
    txn(2'b10, 1'b0, 32'h204, 32'h0, 32'h0BADCAFE, 0, 1);

    // Sync reset while the memory port is locked.
    start_req(2'b00, 1'b1, 32'h300, 32'h77);
    mem_lock = 1'b1;
    @(negedge clk);
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0;
    @(negedge clk);
    chk_quiet("sync_rst");
    mem_lock = 1'b0;
    @(negedge clk);
    chk("sync_rst_lreq", 32'(ldst_req), 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3)) &
                                             (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);
      txn(2'($urandom), 1'($urandom), a, $urandom, $urandom,
          $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
